// File: rtl/systolic_mm_engine_if.sv
// Operand-stream / result-row bundle for systolic_mm_engine.
// master = operand producer and result consumer; slave = the engine.
interface systolic_mm_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 16,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH+$clog2(K_MAX)
);
  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  // Both channels transfer on a cycle where valid & ready are high at the clock edge;
  // valid never waits on ready, and payload holds while valid is high and ready is low.
  logic                            in_valid_i;
  logic                            in_ready_o;
  logic [KW-1:0]                   k_len_i;
  logic                            signed_i;
  logic [N-1:0][DATA_WIDTH-1:0]    a_i;
  logic [N-1:0][DATA_WIDTH-1:0]    b_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [RW-1:0]                   out_row_o;
  logic [N-1:0][OUT_WIDTH-1:0]     c_o;
  logic                            busy_o;

  modport master (
    output in_valid_i, k_len_i, signed_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_row_o, c_o, busy_o
  );

  modport slave (
    input  in_valid_i, k_len_i, signed_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, out_row_o, c_o, busy_o
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic engine, C = A x B over runtime K, row-serial drain.
// Optional build macro MM_ENGINE_SATURATE_EN clamps each result element to OUT_WIDTH.
module systolic_mm_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(K_MAX),
  parameter int OUT_WIDTH  = ACC_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  systolic_mm_engine_if.slave   bus,
  output logic [1:0]            state_o
);
  localparam int KW        = $clog2(K_MAX+1);
  localparam int RW        = (N > 1) ? $clog2(N) : 1;
  localparam int FW        = (N > 1) ? $clog2(2*N) : 1;
  localparam int FLUSH_LEN = 2*N-2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FLUSH = 2'd2, S_DRAIN = 2'd3} state_t;

  state_t          state;
  logic [KW-1:0]   k_eff, beat_cnt, k_sel;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row;
  logic            sgn, sgn_eff, in_ready, in_fire, out_fire, adv, clear;

  logic [DATA_WIDTH-1:0] a_src [N];
  logic [DATA_WIDTH-1:0] b_src [N];
  logic [DATA_WIDTH-1:0] west_in  [N][N];
  logic [DATA_WIDTH-1:0] north_in [N][N];
  logic [ACC_WIDTH-1:0]  acc_all  [N][N];
  logic [ACC_WIDTH-1:0]  acc_sel  [N];

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign in_fire  = bus.in_valid_i && in_ready;
  assign out_fire = (state == S_DRAIN) && bus.out_ready_i;
  assign adv      = in_fire || (state == S_FLUSH);
  assign clear    = out_fire && (row == RW'(N-1));
  // The first beat is multiplied on the same edge that latches signed_i.
  assign sgn_eff  = (state == S_IDLE) ? bus.signed_i : sgn;
  assign k_sel    = (bus.k_len_i == '0 || bus.k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len_i;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state == S_DRAIN);
  assign bus.out_row_o   = row;
  assign bus.busy_o      = (state != S_IDLE);
  assign state_o         = state;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= S_IDLE;
      k_eff     <= '0;
      beat_cnt  <= '0;
      sgn       <= 1'b0;
      flush_cnt <= '0;
      row       <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid_i) begin
          k_eff     <= k_sel;
          sgn       <= bus.signed_i;
          beat_cnt  <= KW'(1);
          flush_cnt <= '0;
          if (k_sel == KW'(1)) state <= (N == 1) ? S_DRAIN : S_FLUSH;
          else                 state <= S_LOAD;
        end
        S_LOAD: if (bus.in_valid_i) begin
          beat_cnt <= beat_cnt + KW'(1);
          if (beat_cnt + KW'(1) == k_eff) state <= (N == 1) ? S_DRAIN : S_FLUSH;
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + FW'(1);
          if (flush_cnt == FW'(FLUSH_LEN-1)) state <= S_DRAIN;
        end
        default: if (bus.out_ready_i) begin
          if (row == RW'(N-1)) begin
            row   <= '0;
            state <= S_IDLE;
          end else begin
            row <= row + RW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_src[i] = (state == S_FLUSH) ? '0 : bus.a_i[i];
      b_src[i] = (state == S_FLUSH) ? '0 : bus.b_i[i];
    end
  end

  // Row i of A and column i of B each see i skew stages before entering the array.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign west_in[0][0]  = a_src[0];
      assign north_in[0][0] = b_src[0];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] a_sh [i];
      logic [DATA_WIDTH-1:0] b_sh [i];
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni || clear) begin
          for (int s = 0; s < i; s++) begin
            a_sh[s] <= '0;
            b_sh[s] <= '0;
          end
        end else if (adv) begin
          a_sh[0] <= a_src[i];
          b_sh[0] <= b_src[i];
          for (int s = 1; s < i; s++) begin
            a_sh[s] <= a_sh[s-1];
            b_sh[s] <= b_sh[s-1];
          end
        end
      end
      assign west_in[i][0]  = a_sh[i-1];
      assign north_in[0][i] = b_sh[i-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [ACC_WIDTH-1:0] acc, wx, nx;
      always_comb begin
        wx = {{(ACC_WIDTH-DATA_WIDTH){sgn_eff & west_in[r][c][DATA_WIDTH-1]}}, west_in[r][c]};
        nx = {{(ACC_WIDTH-DATA_WIDTH){sgn_eff & north_in[r][c][DATA_WIDTH-1]}}, north_in[r][c]};
      end
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)  acc <= '0;
        else if (clear) acc <= '0;
        else if (adv)   acc <= acc + wx * nx;
      end
      assign acc_all[r][c] = acc;

      if (c < N-1) begin : g_east
        logic [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk_i or negedge reset_ni) begin
          if (!reset_ni || clear) a_q <= '0;
          else if (adv)           a_q <= west_in[r][c];
        end
        assign west_in[r][c+1] = a_q;
      end
      if (r < N-1) begin : g_south
        logic [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk_i or negedge reset_ni) begin
          if (!reset_ni || clear) b_q <= '0;
          else if (adv)           b_q <= north_in[r][c];
        end
        assign north_in[r+1][c] = b_q;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) acc_sel[c] = acc_all[row][c];
  end

`ifdef MM_ENGINE_SATURATE_EN
  if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
    localparam logic [OUT_WIDTH-1:0] S_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    always_comb begin
      bus.c_o = '0;
      for (int c = 0; c < N; c++) begin
        if (sgn) begin
          // In range when every bit above the result sign matches it.
          if ((&acc_sel[c][ACC_WIDTH-1:OUT_WIDTH-1]) || !(|acc_sel[c][ACC_WIDTH-1:OUT_WIDTH-1]))
            bus.c_o[c] = acc_sel[c][OUT_WIDTH-1:0];
          else if (acc_sel[c][ACC_WIDTH-1])
            bus.c_o[c] = ~S_MAX;
          else
            bus.c_o[c] = S_MAX;
        end else if (|acc_sel[c][ACC_WIDTH-1:OUT_WIDTH]) begin
          bus.c_o[c] = '1;
        end else begin
          bus.c_o[c] = acc_sel[c][OUT_WIDTH-1:0];
        end
      end
    end
  end else begin : g_full
    always_comb begin
      bus.c_o = '0;
      for (int c = 0; c < N; c++) bus.c_o[c] = acc_sel[c][OUT_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    bus.c_o = '0;
    for (int c = 0; c < N; c++) bus.c_o[c] = acc_sel[c][OUT_WIDTH-1:0];
  end
`endif
endmodule
